// File: rtl/wb_reg_file.sv
// General-purpose register file: one writeback port, two combinational read ports, reg 0 hardwired to zero.
// Optional same-cycle write-through to the read ports: define WB_REG_FILE_BYPASS_EN.
module wb_reg_file #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              RegWrite,
    input  logic [ADDR_W-1:0] WriteReg,
    input  logic [DATA_W-1:0] WriteData,
    input  logic [ADDR_W-1:0] ReadReg1,
    input  logic [ADDR_W-1:0] ReadReg2,
    output logic [DATA_W-1:0] ReadData1,
    output logic [DATA_W-1:0] ReadData2
);
    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] regs [DEPTH];
    logic              wr_en;

    // Writes to reg 0 are dropped here so the bypass path never sees them either.
    assign wr_en = RegWrite && (WriteReg != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
        end else if (wr_en) begin
            regs[WriteReg] <= WriteData;
        end
    end

    // Reads are forced to zero while rst is high so a pending write cannot leak through the bypass.
    always_comb begin
        ReadData1 = '0;
        if (!rst && ReadReg1 != '0) begin
            ReadData1 = regs[ReadReg1];
`ifdef WB_REG_FILE_BYPASS_EN
            if (wr_en && ReadReg1 == WriteReg) ReadData1 = WriteData;
`endif
        end
    end

    always_comb begin
        ReadData2 = '0;
        if (!rst && ReadReg2 != '0) begin
            ReadData2 = regs[ReadReg2];
`ifdef WB_REG_FILE_BYPASS_EN
            if (wr_en && ReadReg2 == WriteReg) ReadData2 = WriteData;
`endif
        end
    end

endmodule

// File: tb/tb_wb_reg_file.sv
// Directed self-checking bench for wb_reg_file; expectations follow WB_REG_FILE_BYPASS_EN when defined.
module tb_wb_reg_file;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

    logic              clk = 1'b0;
    logic              rst;
    logic              RegWrite;
    logic [ADDR_W-1:0] WriteReg;
    logic [DATA_W-1:0] WriteData;
    logic [ADDR_W-1:0] ReadReg1;
    logic [ADDR_W-1:0] ReadReg2;
    logic [DATA_W-1:0] ReadData1;
    logic [DATA_W-1:0] ReadData2;

    int checks   = 0;
    int failures = 0;

`ifdef WB_REG_FILE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    wb_reg_file #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst), .RegWrite(RegWrite), .WriteReg(WriteReg),
        .WriteData(WriteData), .ReadReg1(ReadReg1), .ReadReg2(ReadReg2),
        .ReadData1(ReadData1), .ReadData2(ReadData2)
    );

    always #5 clk = ~clk;

    // Drives one write across a rising edge; inputs change on the falling edge.
    task automatic do_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        @(negedge clk);
        RegWrite = 1'b1; WriteReg = a; WriteData = d;
        @(posedge clk); #1;
        RegWrite = 1'b0;
    endtask

    task automatic test_reset;
        @(negedge clk);
        rst = 1'b1; RegWrite = 1'b1; WriteReg = 5'd6; WriteData = 32'h5555AAAA;
        ReadReg1 = 5'd6; ReadReg2 = 5'd31;
        #1;
        checks++;
        if (ReadData1 !== 32'h0) begin failures++; $display("FAIL reset_hold_rd1 got=%h exp=%h", ReadData1, 32'h0); end
        checks++;
        if (ReadData2 !== 32'h0) begin failures++; $display("FAIL reset_hold_rd2 got=%h exp=%h", ReadData2, 32'h0); end
        @(negedge clk);
        rst = 1'b0; RegWrite = 1'b0;
        do_write(5'd5, 32'hDEADBEEF);
        @(negedge clk);
        ReadReg1 = 5'd5;
        #1;
        checks++;
        if (ReadData1 !== 32'hDEADBEEF) begin failures++; $display("FAIL pre_reset_r5 got=%h exp=%h", ReadData1, 32'hDEADBEEF); end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (ReadData1 !== 32'h0) begin failures++; $display("FAIL async_reset_r5 got=%h exp=%h", ReadData1, 32'h0); end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (ReadData1 !== 32'h0) begin failures++; $display("FAIL post_reset_r5 got=%h exp=%h", ReadData1, 32'h0); end
    endtask

    task automatic test_basic_rw;
        do_write(5'd7, 32'h12345678);
        @(negedge clk);
        ReadReg1 = 5'd7; ReadReg2 = 5'd7;
        #1;
        checks++;
        if (ReadData1 !== 32'h12345678) begin failures++; $display("FAIL basic_rd1 got=%h exp=%h", ReadData1, 32'h12345678); end
        checks++;
        if (ReadData2 !== 32'h12345678) begin failures++; $display("FAIL basic_rd2 got=%h exp=%h", ReadData2, 32'h12345678); end
    endtask

    task automatic test_zero_reg;
        @(negedge clk);
        RegWrite = 1'b1; WriteReg = 5'd0; WriteData = 32'hFFFFFFFF; ReadReg1 = 5'd0; ReadReg2 = 5'd0;
        #1;
        checks++;
        if (ReadData1 !== 32'h0) begin failures++; $display("FAIL zero_no_bypass got=%h exp=%h", ReadData1, 32'h0); end
        @(posedge clk); #1;
        RegWrite = 1'b0;
        checks++;
        if (ReadData1 !== 32'h0) begin failures++; $display("FAIL zero_after_write rd1 got=%h exp=%h", ReadData1, 32'h0); end
        checks++;
        if (ReadData2 !== 32'h0) begin failures++; $display("FAIL zero_after_write rd2 got=%h exp=%h", ReadData2, 32'h0); end
    endtask

    task automatic test_write_disable;
        @(negedge clk);
        RegWrite = 1'b0; WriteReg = 5'd3; WriteData = 32'hA5A5A5A5; ReadReg1 = 5'd3;
        #1;
        checks++;
        if (ReadData1 !== 32'h0) begin failures++; $display("FAIL disable_pre_edge got=%h exp=%h", ReadData1, 32'h0); end
        @(posedge clk); #1;
        checks++;
        if (ReadData1 !== 32'h0) begin failures++; $display("FAIL disable_post_edge got=%h exp=%h", ReadData1, 32'h0); end
    endtask

    task automatic test_hazard;
        logic [DATA_W-1:0] exp_pre;
        exp_pre = BYPASS ? 32'h2 : 32'h1;
        do_write(5'd9, 32'h1);
        @(negedge clk);
        RegWrite = 1'b1; WriteReg = 5'd9; WriteData = 32'h2; ReadReg1 = 5'd7; ReadReg2 = 5'd9;
        #1;
        checks++;
        if (ReadData2 !== exp_pre) begin failures++; $display("FAIL hazard_pre_edge got=%h exp=%h", ReadData2, exp_pre); end
        checks++;
        if (ReadData1 !== 32'h12345678) begin failures++; $display("FAIL hazard_other_port got=%h exp=%h", ReadData1, 32'h12345678); end
        @(posedge clk); #1;
        RegWrite = 1'b0;
        checks++;
        if (ReadData2 !== 32'h2) begin failures++; $display("FAIL hazard_post_edge got=%h exp=%h", ReadData2, 32'h2); end
    endtask

    task automatic test_reset_mid_write;
        @(negedge clk);
        RegWrite = 1'b1; WriteReg = 5'd4; WriteData = 32'hCAFEF00D; ReadReg1 = 5'd4;
        #2 rst = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (ReadData1 !== 32'h0) begin failures++; $display("FAIL reset_wins got=%h exp=%h", ReadData1, 32'h0); end
        @(negedge clk);
        rst = 1'b0; WriteData = 32'h0BADF00D;
        @(posedge clk); #1;
        RegWrite = 1'b0;
        checks++;
        if (ReadData1 !== 32'h0BADF00D) begin failures++; $display("FAIL first_write_after_reset got=%h exp=%h", ReadData1, 32'h0BADF00D); end
    endtask

    task automatic test_sweep;
        logic [DATA_W-1:0] e1, e2;
        for (int i = 1; i < 32; i++) do_write(ADDR_W'(i), 32'(i) * 32'h01010101);
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            ReadReg1 = ADDR_W'(i); ReadReg2 = ADDR_W'(31 - i);
            e1 = 32'(i) * 32'h01010101;
            e2 = 32'(31 - i) * 32'h01010101;
            #1;
            checks++;
            if (ReadData1 !== e1) begin failures++; $display("FAIL sweep_rd1 idx=%0d got=%h exp=%h", i, ReadData1, e1); end
            checks++;
            if (ReadData2 !== e2) begin failures++; $display("FAIL sweep_rd2 idx=%0d got=%h exp=%h", 31 - i, ReadData2, e2); end
        end
    endtask

    initial begin
        rst = 1'b1; RegWrite = 1'b0; WriteReg = '0; WriteData = '0; ReadReg1 = '0; ReadReg2 = '0;
        test_reset();
        test_basic_rw();
        test_zero_reg();
        test_write_disable();
        test_hazard();
        test_reset_mid_write();
        test_sweep();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
